fir_tap_sequencer: RTL and testbench
====================================

Name: fir_tap_sequencer

Overview:
- Control-and-accumulate engine for the 64-tap, 16-bit FIR.
- Accepts one input sample per transaction and pulses the sample delay-line memory's shift-load enable.
- Sweeps a shared tap address across the delay line and the coefficient memory, then multiply-accumulates the returned words and delivers one rounded, saturated Q15 output sample per input sample over a valid/ready handshake.
- Sits between the input sample stream, the sample/coefficient memories and the downstream output consumer.

Parameters:
- DW, 16, sample/coefficient/output width (signed, Q1.(DW-1)).
- TAPS, 64, number of taps; power of two.
- AW, 6, tap address width, log2(TAPS).
- ACCW, 38, accumulator width, 2*DW + AW.

Ports:
- clk  input  1  clock, all state on rising edge.
- resetn  input  1  synchronous, active-low reset.
- in_data  input  DW  signed input sample.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a sample.
- mem_load_en  output  1  one-cycle shift-load strobe to the sample delay line.
- mem_load_data  output  DW  sample to shift in; held stable while mem_load_en=1.
- tap_addr  output  AW  read address to both the delay line (0 = newest) and the coefficient memory.
- sample_rdata  input  DW  delay-line word at tap_addr, combinational same cycle.
- coeff_rdata  input  DW  coefficient at tap_addr, combinational same cycle.
- out_data  output  DW  filtered sample.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (resetn=0 at clk edge): state=IDLE, accumulator=0, product register=0, tap_addr=0, mem_load_en=0, mem_load_data=0, out_data=0, out_valid=0, busy=0. Reset has priority over everything, including mid-sweep. A partial sum is discarded. A pending output is dropped.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register in_data into mem_load_data, clear accumulator, go to LOAD.
- LOAD: one cycle.
  - mem_load_en=1, tap_addr=0, in_ready=0, go to RUN.
  - The memory shifts at the end of this cycle, so tap 0 is the new sample during RUN.
- RUN: TAPS cycles.
  - tap_addr counts 0..TAPS-1, one per cycle.
  - Each cycle the product sample_rdata*coeff_rdata (signed, 2*DW bits) is registered.
  - The previously registered product is sign-extended to ACCW and added to the accumulator.
  - Addition does not occur in the first RUN cycle; product register is cleared in LOAD.
  - After tap_addr=TAPS-1, go to DRAIN; tap_addr wraps to 0.
- DRAIN: one cycle; final product is accumulated; go to DONE.
- DONE: out_valid=1.
  - out_data = sat_DW((acc + 2^(DW-2)) >>> (DW-1)), i.e. round-half-up, arithmetic shift, saturate to [-2^(DW-1), 2^(DW-1)-1].
  - out_data is registered on DRAIN->DONE and held stable until accepted.
  - On out_ready=1: out_valid falls on the next edge, go to IDLE.
- Latency: accept edge to out_valid high = TAPS+3 cycles (67 at defaults). Minimum throughput is one sample per TAPS+4 cycles with out_ready tied high.
- in_ready is 0 in LOAD, RUN, DRAIN and DONE. in_valid in those states is ignored, and the source must hold its data.
- mem_load_en never asserts outside LOAD and is exactly one cycle per accepted sample.
- The accumulator cannot overflow at ACCW = 2*DW+AW. The only overflow is at the output saturation.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset mid-RUN (tap_addr=20) -> next cycle IDLE, in_ready=1, out_valid=0, tap_addr=0, no mem_load_en. A following sample produces a normal result with no stale sum.
- Impulse: coeff[0]=0x4000, others 0; input 0x2000 -> mem_load_en pulses once; tap_addr steps 0..63; out_data=0x1000 with out_valid exactly 67 cycles after accept.
- Rounding: coeff[0]=0x0001, sample 0x4000 -> acc=0x4000, out_data=0x0001. With sample 0x3FFF -> out_data=0x0000.
- Saturation: all coeffs 0x7FFF, 64 samples of 0x7FFF -> out_data=0x7FFF. All coeffs 0x7FFF, 64 samples of 0x8000 -> out_data=0x8000.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_data/out_valid stable, in_ready=0, in_valid pulses ignored (no extra mem_load_en). out_ready=1 -> IDLE next cycle.
- Streaming: 100 random samples/coeffs, out_ready random -> outputs match golden convolution bit-exact; mem_load_en count = accepted samples.

Source files
------------

// File: rtl/fir_tap_sequencer_if.sv
// fir_tap_sequencer_if: groups the three buses around the FIR sequencer:
// the input sample stream, the shared delay-line/coefficient memory port,
// and the output sample stream. The sequencer connects through the master
// modport; the surrounding memories, source and consumer use the slave modport.
interface fir_tap_sequencer_if #(
    parameter int DW = 16,
    parameter int AW = 6
) ();
    // input sample stream
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;

    // delay-line load and shared tap read port
    logic          mem_load_en;
    logic [DW-1:0] mem_load_data;
    logic [AW-1:0] tap_addr;
    logic [DW-1:0] sample_rdata;
    logic [DW-1:0] coeff_rdata;

    // output sample stream
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_load_en,
        output mem_load_data,
        output tap_addr,
        input  sample_rdata,
        input  coeff_rdata,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_load_en,
        input  mem_load_data,
        input  tap_addr,
        output sample_rdata,
        output coeff_rdata,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: accepts one input sample, strobes it into the sample
// delay line, sweeps the shared tap address across the delay line and the
// coefficient memory, multiply-accumulates the returned words and presents
// one rounded, saturated Q1.(DW-1) output sample over valid/ready.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a sample; in_ready high
// LOAD  | one-cycle shift-load strobe; product register cleared
// RUN   | TAPS cycles; tap_addr 0..TAPS-1, product registered each cycle
// DRAIN | last registered product folded in; rounded result registered
// DONE  | out_valid high, out_data held until out_ready
module fir_tap_sequencer #(
    parameter int DW   = 16,
    parameter int TAPS = 64,
    parameter int AW   = 6,
    parameter int ACCW = 38
) (
    input  logic                 clk,
    input  logic                 resetn,
    fir_tap_sequencer_if.master  bus,
    output logic                 busy
);

    localparam int              PW       = 2 * DW;
    localparam int              SHW      = ACCW - DW + 1;
    localparam logic [AW-1:0]   LAST_TAP = AW'(TAPS - 1);
    localparam logic [DW-1:0]   OUT_MAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]   OUT_MIN  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [AW-1:0]   tap_addr;
    logic [DW-1:0]   load_data;
    logic [DW-1:0]   out_data;
    logic [PW-1:0]   prod;
    logic [PW-1:0]   prod_nxt;
    logic [PW-1:0]   samp_ext;
    logic [PW-1:0]   coef_ext;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] acc_sum;
    logic [SHW-1:0]  acc_rnd;
    logic [DW-1:0]   out_sat;

    assign bus.tap_addr      = tap_addr;
    assign bus.mem_load_data = load_data;
    assign bus.out_data      = out_data;

    // The low PW bits of the product of the sign-extended operands are the
    // exact signed DWxDW product, so a plain multiply is enough here.
    assign samp_ext = {{DW{bus.sample_rdata[DW-1]}}, bus.sample_rdata};
    assign coef_ext = {{DW{bus.coeff_rdata[DW-1]}}, bus.coeff_rdata};
    assign prod_nxt = samp_ext * coef_ext;

    // Registered product sign-extended into the accumulator. ACCW leaves
    // AW guard bits, so this sum never wraps.
    assign acc_sum = acc + {{(ACCW-PW){prod[PW-1]}}, prod};

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state handshake/strobe outputs
    always_comb begin
        state_nxt       = state;
        bus.in_ready    = 1'b0;
        bus.mem_load_en = 1'b0;
        bus.out_valid   = 1'b0;
        busy            = 1'b1;
        unique case (state)
            S_IDLE: begin
                busy         = 1'b0;
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                bus.mem_load_en = 1'b1;
                state_nxt       = S_RUN;
            end
            S_RUN: begin
                if (tap_addr == LAST_TAP) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Round half up and shift right by DW-1 in one step: adding 2^(DW-2)
    // to the dropped low bits carries into the kept part exactly when bit
    // DW-2 is set. Then saturate unless all bits above the output sign agree.
    always_comb begin
        acc_rnd = acc_sum[ACCW-1:DW-1] + SHW'(acc_sum[DW-2]);
        out_sat = acc_rnd[DW-1:0];
        if (!((&acc_rnd[SHW-1:DW-1]) || !(|acc_rnd[SHW-1:DW-1]))) begin
            out_sat = acc_rnd[SHW-1] ? OUT_MIN : OUT_MAX;
        end
    end

    // Datapath: sample capture, tap sweep, product pipeline, accumulate and
    // output register. A reset mid-sweep throws away the partial sum.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            load_data <= '0;
            tap_addr  <= '0;
            prod      <= '0;
            acc       <= '0;
            out_data  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        load_data <= bus.in_data;
                        acc       <= '0;
                    end
                end
                S_LOAD: begin
                    // Clearing the product here makes the first RUN-cycle
                    // add a no-op, so RUN needs no first-cycle special case.
                    prod     <= '0;
                    tap_addr <= '0;
                end
                S_RUN: begin
                    prod     <= prod_nxt;
                    acc      <= acc_sum;
                    tap_addr <= tap_addr + AW'(1);
                end
                S_DRAIN: begin
                    acc      <= acc_sum;
                    out_data <= out_sat;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: drives samples into the FIR sequencer, models the
// delay-line and coefficient memories, and checks every output sample
// against a direct convolution of the accepted-sample history.
module tb_fir_tap_sequencer;

    localparam int DW   = 16;
    localparam int TAPS = 64;
    localparam int AW   = 6;
    localparam int ACCW = 38;

    logic clk = 1'b0;
    logic resetn;
    logic busy;

    fir_tap_sequencer_if #(.DW(DW), .AW(AW)) bus ();

    fir_tap_sequencer #(
        .DW   (DW),
        .TAPS (TAPS),
        .AW   (AW),
        .ACCW (ACCW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // ---------------- memory models ----------------
    logic [DW-1:0] dl [TAPS];
    shortint       coef [TAPS];
    logic          clr_dl;

    always @(posedge clk) begin
        if (clr_dl) begin
            for (int k = 0; k < TAPS; k++) dl[k] <= '0;
        end else if (bus.mem_load_en) begin
            dl[0] <= bus.mem_load_data;
            for (int k = 1; k < TAPS; k++) dl[k] <= dl[k-1];
        end
    end

    assign bus.sample_rdata = dl[bus.tap_addr];
    assign bus.coeff_rdata  = coef[bus.tap_addr];

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_load = 0;
    int n_acc  = 0;
    int n_exp  = 0;
    int n_out  = 0;
    int accept_cyc = 0;
    int first_valid_cyc = 0;
    logic ov_prev = 1'b0;
    logic [DW-1:0] last_out = '0;

    shortint       ref_hist [$];
    logic [DW-1:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // y = sat( floor((sum_k x[n-k]*h[k] + 2^14) / 2^15) )
    function automatic logic [DW-1:0] ref_out();
        longint s = 0;
        longint r;
        for (int k = 0; k < TAPS; k++) s += longint'(ref_hist[k]) * longint'(coef[k]);
        r = (s + 64'sd16384) >>> 15;
        if (r > 64'sd32767) r = 64'sd32767;
        else if (r < -64'sd32768) r = -64'sd32768;
        return DW'(r);
    endfunction

    task automatic clear_hist();
        ref_hist.delete();
        for (int k = 0; k < TAPS; k++) ref_hist.push_back(16'sd0);
        clr_dl = 1'b1;
        tick();
        clr_dl = 1'b0;
    endtask

    // Returns one cycle after acceptance, i.e. with the DUT in LOAD.
    task automatic send(input logic [DW-1:0] d);
        int n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 500) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready still 0 after %0d cycles, expected 1", n);
            bus.in_valid = 1'b0;
            return;
        end
        ref_hist.push_front(shortint'(d));
        void'(ref_hist.pop_back());
        exp_q.push_back(ref_out());
        n_acc++;
        n_exp++;
        accept_cyc = cyc;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int target);
        int n = 0;
        while (n_out < target && n < 5000) begin
            tick();
            n++;
        end
        check("out_count", 64'(n_out), 64'(target));
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (bus.mem_load_en) n_load++;
                if (bus.out_valid && !ov_prev) first_valid_cyc = cyc;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL out_unexpected: got 0x%0h, expected no output", bus.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 64'(bus.out_data), 64'(e));
                    end
                    last_out = bus.out_data;
                    n_out++;
                end
            end
            ov_prev = bus.out_valid;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int ld0;
        int bad;
        int n;
        logic [DW-1:0] d0;
        logic stream_done;

        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        clr_dl        = 1'b1;
        stream_done   = 1'b0;
        for (int k = 0; k < TAPS; k++) coef[k] = 16'sd0;
        for (int k = 0; k < TAPS; k++) ref_hist.push_back(16'sd0);
        repeat (3) tick();

        check("rst_in_ready",   64'(bus.in_ready),      64'd1);
        check("rst_busy",       64'(busy),              64'd0);
        check("rst_out_valid",  64'(bus.out_valid),     64'd0);
        check("rst_load_en",    64'(bus.mem_load_en),   64'd0);
        check("rst_tap_addr",   64'(bus.tap_addr),      64'd0);
        check("rst_out_data",   64'(bus.out_data),      64'd0);
        check("rst_load_data",  64'(bus.mem_load_data), 64'd0);
        clr_dl = 1'b0;
        resetn = 1'b1;
        tick();

        // impulse: h[0]=0.5, x=0.25 -> 0.125
        coef[0] = 16'sh4000;
        clear_hist();
        ld0 = n_load;
        send(16'h2000);
        check("imp_load_en", 64'(bus.mem_load_en), 64'd1);
        bad = 0;
        for (int j = 0; j < TAPS; j++) begin
            tick();
            if (bus.tap_addr != AW'(j) || bus.mem_load_en) bad++;
        end
        check("imp_tap_sweep_errors", 64'(bad), 64'd0);
        wait_outputs(n_exp);
        check("imp_latency",  64'(first_valid_cyc - accept_cyc), 64'd67);
        check("imp_out",      64'(last_out), 64'h1000);
        check("imp_load_cnt", 64'(n_load - ld0), 64'd1);

        // rounding: half rounds up, just below half rounds down
        for (int k = 0; k < TAPS; k++) coef[k] = 16'sd0;
        coef[0] = 16'sd1;
        clear_hist();
        send(16'h4000);
        wait_outputs(n_exp);
        check("rnd_half_up", 64'(last_out), 64'h0001);
        send(16'h3FFF);
        wait_outputs(n_exp);
        check("rnd_below_half", 64'(last_out), 64'h0000);

        // saturation at both rails
        for (int k = 0; k < TAPS; k++) coef[k] = 16'sh7FFF;
        for (int i = 0; i < TAPS; i++) send(16'h7FFF);
        wait_outputs(n_exp);
        check("sat_pos", 64'(last_out), 64'h7FFF);
        for (int i = 0; i < TAPS; i++) send(16'h8000);
        wait_outputs(n_exp);
        check("sat_neg", 64'(last_out), 64'h8000);

        // backpressure in DONE
        for (int k = 0; k < TAPS; k++) coef[k] = shortint'(int'($urandom_range(0, 8191)) - 4096);
        bus.out_ready = 1'b0;
        send(DW'($urandom));
        n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        check("bp_valid_seen", 64'(bus.out_valid), 64'd1);
        d0  = bus.out_data;
        ld0 = n_load;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid_hold", 64'(bus.out_valid), 64'd1);
            check("bp_data_hold",  64'(bus.out_data),  64'(d0));
            check("bp_in_ready",   64'(bus.in_ready),  64'd0);
            bus.in_valid = i[0];
            bus.in_data  = DW'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        check("bp_no_extra_load", 64'(n_load - ld0), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        check("bp_idle_in_ready",  64'(bus.in_ready),  64'd1);
        check("bp_idle_out_valid", 64'(bus.out_valid), 64'd0);
        check("bp_idle_busy",      64'(busy),          64'd0);

        // reset in the middle of the sweep
        send(DW'($urandom));
        n = 0;
        while (bus.tap_addr != AW'(20) && n < 100) begin
            tick();
            n++;
        end
        check("mr_reached_tap20", 64'(bus.tap_addr), 64'd20);
        ld0 = n_load;
        resetn = 1'b0;
        tick();
        check("mr_in_ready",  64'(bus.in_ready),    64'd1);
        check("mr_out_valid", 64'(bus.out_valid),   64'd0);
        check("mr_tap_addr",  64'(bus.tap_addr),    64'd0);
        check("mr_busy",      64'(busy),            64'd0);
        check("mr_load_en",   64'(bus.mem_load_en), 64'd0);
        resetn = 1'b1;
        exp_q.delete();
        n_exp--;
        check("mr_no_load", 64'(n_load - ld0), 64'd0);
        send(DW'($urandom));
        wait_outputs(n_exp);

        // streaming with random coefficients, samples and out_ready
        for (int k = 0; k < TAPS; k++) begin
            if (k < 8) coef[k] = shortint'($urandom_range(0, 65535));
            else       coef[k] = shortint'(int'($urandom_range(0, 8191)) - 4096);
        end
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    send(DW'($urandom));
                    repeat ($urandom_range(0, 3)) tick();
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_outputs(n_exp);
        check("stream_queue_empty", 64'(exp_q.size()), 64'd0);
        check("load_count_total",   64'(n_load),       64'(n_acc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
